mode7_scan: RTL

MODE7_SCAN -- requirements
Module: mode7_scan

---
 rtl/mode7_pkg.sv | 29 ++
 rtl/mode7_pix_fifo.sv | 84 ++++++++
 rtl/mode7_scan.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mode7_pkg.sv
// Shared types and widths for the mode-7 scanline request/collect path.
package mode7_pkg;

  localparam int CW    = 16;
  localparam int PW    = 8;
  localparam int PIX_W = PW + 2 * CW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [PW-1:0] color;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          last;
  } pix_t;

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v, input logic [CW-1:0] max);
    if (v == max) begin
      return 16'd0;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/mode7_pix_fifo.sv
// Pixel FIFO with occupancy count; any DEPTH, pointers wrap explicitly.
module mode7_pix_fifo
  import mode7_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PIX_W,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [W-1:0]    din,
  input  logic            pop,
  output logic [W-1:0]    dout,
  output logic            empty,
  output logic            full,
  output logic [CNTW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [W-1:0]    mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            do_push_s;
  logic            do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == LAST_IDX) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Status flags; push+pop together is accepted even when full or empty.
  always_comb begin
    empty     = (count_r == {CNTW{1'b0}});
    full      = (count_r == FULL_CNT);
    do_push_s = push && (!full || pop);
    do_pop_s  = pop && (!empty || push);
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNTW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + CNTW'(1);
      end else if (do_pop_s && !do_push_s) begin
        count_r <= count_r - CNTW'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Storage, cleared on reset so a stale head never shows after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/mode7_scan.sv
// Raster scan of screen coordinates into a fixed-latency transform unit,
// collecting returned texels into a credit-limited pixel stream.
module mode7_scan
  import mode7_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int LAT      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] y_out,
  output logic          xy_valid,
  input  logic [PW-1:0] color_in,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [PW-1:0] pix_data,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_last
);

  localparam int DEPTH = LAT + 2;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] X_MAX   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_MAX   = CW'(V_ACTIVE - 1);
  localparam logic [CNTW:0] DEPTH_W = (CNTW + 1)'(DEPTH);

  state_e          state_r;
  state_e          state_s;
  logic [CW-1:0]   x_r;
  logic [CW-1:0]   y_r;
  logic [CNTW-1:0] inflight_r;
  logic [CNTW-1:0] fifo_count_s;
  logic [CNTW:0]   occ_s;
  logic [LAT-1:0]  vld_r;
  logic [2*CW:0]   tag_r [LAT];
  logic            done_r;
  logic            issue_s;
  logic            last_req_s;
  logic            credit_s;
  logic            emerge_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            pop_s;
  logic            last_acc_s;
  pix_t            push_data_s;
  pix_t            head_s;

  // Credit counts both queued pixels and requests still inside the transform.
  always_comb begin
    last_req_s  = (x_r == X_MAX) && (y_r == Y_MAX);
    occ_s       = {1'b0, fifo_count_s} + {1'b0, inflight_r};
    credit_s    = (occ_s < DEPTH_W);
    emerge_s    = vld_r[LAT-1];
    push_data_s = {color_in, tag_r[LAT-1]};
    pop_s       = !fifo_empty_s && pix_ready;
    last_acc_s  = pop_s && head_s.last;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state; a 1x1 frame issues its only request from IDLE and skips RUN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && credit_s) begin
          state_s = last_req_s ? ST_DRAIN : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && last_req_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (last_acc_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Request issue; the start cycle already carries (0,0).
  always_comb begin
    issue_s = 1'b0;
    case (state_r)
      ST_IDLE:  issue_s = start && credit_s;
      ST_RUN:   issue_s = credit_s;
      ST_DRAIN: issue_s = 1'b0;
      default:  issue_s = 1'b0;
    endcase
  end

  // Raster counters; the last request wraps both back to (0,0) for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= 16'd0;
      y_r <= 16'd0;
    end else if (issue_s) begin
      x_r <= wrap_inc(x_r, X_MAX);
      if (x_r == X_MAX) begin
        y_r <= wrap_inc(y_r, Y_MAX);
      end
    end
  end

  // Requests in flight inside the transform unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= {CNTW{1'b0}};
    end else begin
      case ({issue_s, emerge_s})
        2'b10:   inflight_r <= inflight_r + CNTW'(1);
        2'b01:   inflight_r <= inflight_r - CNTW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Tag pipeline aligned with the transform latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        tag_r[i] <= {(2 * CW + 1){1'b0}};
      end
    end else begin
      vld_r[0] <= issue_s;
      tag_r[0] <= {x_r, y_r, last_req_s};
      for (int i = 1; i < LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // End-of-frame pulse, one cycle after the final beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= last_acc_s;
    end
  end

  mode7_pix_fifo #(
    .DEPTH(DEPTH),
    .W    (PIX_W),
    .CNTW (CNTW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (emerge_s),
    .din  (push_data_s),
    .pop  (pop_s),
    .dout (head_s),
    .empty(fifo_empty_s),
    .full (fifo_full_s),
    .count(fifo_count_s)
  );

  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;
  assign x_out     = x_r;
  assign y_out     = y_r;
  assign xy_valid  = issue_s;
  assign pix_valid = !fifo_empty_s;
  assign pix_data  = head_s.color;
  assign pix_x     = head_s.x;
  assign pix_y     = head_s.y;
  assign pix_last  = head_s.last;

endmodule
